// File: rtl/cam_pkg.sv
// Shared CAM definitions: write/clear FSM encoding and an index-width helper.
package cam_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Never returns less than 1 so a single-entry vector still gets a usable index port.
  function automatic int cam_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder: reports any-set, lowest set index and more-than-one-set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = cam_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic             multiple
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign found = |vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multiple = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/tcam_lookup_engine.sv
// Ternary/binary CAM for the output-port lookup path: write/invalidate/clear-all side plus a
// fixed two-stage lookup pipeline (hit vector, then priority encode) accepting one key per cycle.
module tcam_lookup_engine
  import cam_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_TERNARY    = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    WE,
  input  logic [C_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [C_DATA_WIDTH-1:0] DIN,
  input  logic [C_DATA_WIDTH-1:0] DATA_MASK,
  input  logic                    WR_VALID,
  input  logic                    CLR,
  output logic                    BUSY,
  input  logic                    CMP_REQ,
  input  logic [C_DATA_WIDTH-1:0] CMP_DIN,
  output logic                    MATCH_VLD,
  output logic                    MATCH,
  output logic [C_ADDR_WIDTH-1:0] MATCH_ADDR,
  output logic                    MULTIPLE_MATCH
);

  localparam int DEPTH = 1 << C_ADDR_WIDTH;

  logic [C_DATA_WIDTH-1:0] key_mem  [DEPTH];
  logic [C_DATA_WIDTH-1:0] mask_mem [DEPTH];
  logic [DEPTH-1:0]        valid;
  logic [0:0]              state;
  logic [C_ADDR_WIDTH-1:0] clr_cnt;
  logic                    wr_ok;
  logic [DEPTH-1:0]        hit_vec;
  logic                    s1_vld;
  logic [DEPTH-1:0]        s1_hit;
  logic                    enc_found;
  logic [C_ADDR_WIDTH-1:0] enc_idx;
  logic                    enc_multi;

  assign BUSY  = (state == ST_CLEAR);
  // A clear request in the same cycle takes priority and the write is lost.
  assign wr_ok = WE && !CLR && (state == ST_IDLE);

  // Key/mask storage carries no reset; the valid bits alone decide whether an entry exists.
  always_ff @(posedge CLK) begin
    if (wr_ok && WR_VALID) begin
      key_mem[WR_ADDR]  <= DIN;
      mask_mem[WR_ADDR] <= (C_TERNARY != 0) ? DATA_MASK : '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid   <= '0;
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLR) begin
            state <= ST_CLEAR;
          end else if (WE) begin
            valid[WR_ADDR] <= WR_VALID;
          end
        end
        ST_CLEAR: begin
          valid[clr_cnt] <= 1'b0;
          if (&clr_cnt) begin
            clr_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Compared against the table as it stands before this edge's write or clear step.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid[i] && (((CMP_DIN ^ key_mem[i]) & ~mask_mem[i]) == '0);
    end
  end

  cam_prio_enc #(
    .WIDTH (DEPTH),
    .IDX_W (C_ADDR_WIDTH)
  ) u_prio_enc (
    .vec      (s1_hit),
    .found    (enc_found),
    .idx      (enc_idx),
    .multiple (enc_multi)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vld         <= 1'b0;
      s1_hit         <= '0;
      MATCH_VLD      <= 1'b0;
      MATCH          <= 1'b0;
      MATCH_ADDR     <= '0;
      MULTIPLE_MATCH <= 1'b0;
    end else begin
      s1_vld    <= CMP_REQ;
      MATCH_VLD <= s1_vld;
      if (CMP_REQ) s1_hit <= hit_vec;
      // Result registers only move on a real result so idle cycles hold the last answer.
      if (s1_vld) begin
        MATCH          <= enc_found;
        MATCH_ADDR     <= enc_idx;
        MULTIPLE_MATCH <= enc_multi;
      end
    end
  end

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// Drives a ternary and a binary CAM instance with shared stimulus and checks both against a table model.
module tb_tcam_lookup_engine;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] din;
  logic [DW-1:0] data_mask;
  logic          wr_valid;
  logic          clr;
  logic          cmp_req;
  logic [DW-1:0] cmp_din;

  logic [1:0]         busy;
  logic [1:0]         match_vld;
  logic [1:0]         match;
  logic [1:0][AW-1:0] match_addr;
  logic [1:0]         multiple_match;

  tcam_lookup_engine #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TERNARY(1)) u_tcam (
    .CLK(clk), .RESET(rst), .WE(we), .WR_ADDR(wr_addr), .DIN(din), .DATA_MASK(data_mask),
    .WR_VALID(wr_valid), .CLR(clr), .BUSY(busy[0]), .CMP_REQ(cmp_req), .CMP_DIN(cmp_din),
    .MATCH_VLD(match_vld[0]), .MATCH(match[0]), .MATCH_ADDR(match_addr[0]),
    .MULTIPLE_MATCH(multiple_match[0])
  );

  tcam_lookup_engine #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TERNARY(0)) u_bcam (
    .CLK(clk), .RESET(rst), .WE(we), .WR_ADDR(wr_addr), .DIN(din), .DATA_MASK(data_mask),
    .WR_VALID(wr_valid), .CLR(clr), .BUSY(busy[1]), .CMP_REQ(cmp_req), .CMP_DIN(cmp_din),
    .MATCH_VLD(match_vld[1]), .MATCH(match[1]), .MATCH_ADDR(match_addr[1]),
    .MULTIPLE_MATCH(multiple_match[1])
  );

  // Reference table: index 0 of the result arrays is the ternary instance, 1 the binary one.
  bit [DW-1:0] m_key  [DEPTH];
  bit [DW-1:0] m_mask [DEPTH];
  bit          m_valid[DEPTH];
  bit          m_busy;
  int          m_cpos;
  bit          p1_vld, p2_vld;
  bit          p1_match[2], p2_match[2], p1_multi[2], p2_multi[2];
  bit [AW-1:0] p1_addr[2], p2_addr[2];
  bit          e_match[2], e_multi[2];
  bit [AW-1:0] e_addr[2];

  int n_vec;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_cpos = 0;
    p1_vld = 1'b0;
    p2_vld = 1'b0;
    for (int t = 0; t < 2; t++) begin
      e_match[t] = 1'b0;
      e_addr[t]  = '0;
      e_multi[t] = 1'b0;
    end
  endfunction

  function automatic void model_lookup(input int t, input bit [DW-1:0] key,
                                       output bit m, output bit [AW-1:0] a, output bit mu);
    int n;
    bit [DW-1:0] care;
    n = 0;
    a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      care = (t == 0) ? ~m_mask[i] : 16'hFFFF;
      if (m_valid[i] && (((key ^ m_key[i]) & care) == 16'h0)) begin
        if (n == 0) a = AW'(i);
        n++;
      end
    end
    m  = (n > 0);
    mu = (n > 1);
  endfunction

  // Everything that happens to the table and the result pipe on one rising edge.
  function automatic void model_edge();
    bit          lm[2];
    bit          lmu[2];
    bit [AW-1:0] la[2];
    for (int t = 0; t < 2; t++) model_lookup(t, cmp_din, lm[t], la[t], lmu[t]);
    p2_vld   = p1_vld;
    p2_match = p1_match;
    p2_addr  = p1_addr;
    p2_multi = p1_multi;
    p1_vld   = cmp_req;
    p1_match = lm;
    p1_addr  = la;
    p1_multi = lmu;
    if (m_busy) begin
      m_valid[m_cpos] = 1'b0;
      m_cpos++;
      if (m_cpos == DEPTH) begin
        m_busy = 1'b0;
        m_cpos = 0;
      end
    end else if (clr) begin
      m_busy = 1'b1;
      m_cpos = 0;
    end else if (we) begin
      m_valid[wr_addr] = wr_valid;
      if (wr_valid) begin
        m_key[wr_addr]  = din;
        m_mask[wr_addr] = data_mask;
      end
    end
    if (p2_vld) begin
      e_match = p2_match;
      e_addr  = p2_addr;
      e_multi = p2_multi;
    end
  endfunction

  task automatic check_all();
    for (int t = 0; t < 2; t++) begin
      check($sformatf("busy%0d", t), busy[t], m_busy);
      check($sformatf("match_vld%0d", t), match_vld[t], p2_vld);
      check($sformatf("match%0d", t), match[t], e_match[t]);
      check($sformatf("match_addr%0d", t), match_addr[t], e_addr[t]);
      check($sformatf("multiple%0d", t), multiple_match[t], e_multi[t]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_idle();
    we = 1'b0; wr_addr = '0; din = '0; data_mask = '0; wr_valid = 1'b0;
    clr = 1'b0; cmp_req = 1'b0; cmp_din = '0;
  endtask

  task automatic do_write(input bit [AW-1:0] a, input bit [DW-1:0] k, input bit [DW-1:0] m,
                          input bit v);
    set_idle();
    we = 1'b1; wr_addr = a; din = k; data_mask = m; wr_valid = v;
    step();
    set_idle();
  endtask

  // Ternary-instance lookup with the hand-worked answer; the model covers both instances too.
  task automatic do_lookup(input string tag, input bit [DW-1:0] k, input bit em,
                           input bit [AW-1:0] ea, input bit emu);
    set_idle();
    cmp_req = 1'b1; cmp_din = k;
    step();
    set_idle();
    step();
    check({tag, "_vld"}, match_vld[0], 1);
    check({tag, "_match"}, match[0], em);
    check({tag, "_addr"}, match_addr[0], ea);
    check({tag, "_multi"}, multiple_match[0], emu);
  endtask

  initial begin
    int cnt;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    do_write(4'd3, 16'hABCD, 16'h0000, 1'b1);
    do_lookup("t1", 16'hABCD, 1'b1, 4'd3, 1'b0);

    do_write(4'd5, 16'h1200, 16'h00FF, 1'b1);
    do_write(4'd9, 16'h1234, 16'h0000, 1'b1);
    do_lookup("t2a", 16'h1234, 1'b1, 4'd5, 1'b1);
    do_lookup("t2b", 16'h12FF, 1'b1, 4'd5, 1'b0);

    do_write(4'd5, 16'h0000, 16'h0000, 1'b0);
    do_lookup("t3a", 16'h1234, 1'b1, 4'd9, 1'b0);
    do_lookup("t3b", 16'h5555, 1'b0, 4'd0, 1'b0);

    // Clear-all with three live entries and a write attempted mid-clear.
    do_write(4'd12, 16'h0000, 16'hFFFF, 1'b1);
    set_idle();
    clr = 1'b1;
    step();
    set_idle();
    cnt = busy[0] ? 1 : 0;
    for (int g = 0; g < 40 && busy[0]; g++) begin
      set_idle();
      if (cnt == 4) begin
        we = 1'b1; wr_addr = 4'd7; din = 16'h7777; wr_valid = 1'b1;
      end
      step();
      if (busy[0]) cnt++;
    end
    set_idle();
    check("t4_busy_cycles", cnt, 16);
    do_lookup("t4a", 16'h7777, 1'b0, 4'd0, 1'b0);
    do_lookup("t4b", 16'hABCD, 1'b0, 4'd0, 1'b0);

    // Eight back-to-back lookups; the first shares its cycle with the write of the target.
    for (int i = 0; i < 10; i++) begin
      set_idle();
      if (i < 8) begin
        cmp_req = 1'b1; cmp_din = 16'hC0DE;
      end
      if (i == 0) begin
        we = 1'b1; wr_addr = 4'd2; din = 16'hC0DE; wr_valid = 1'b1;
      end
      step();
      if (i >= 1 && i <= 8) begin
        check("t5_vld", match_vld[0], 1);
        check("t5_match", match[0], (i == 1) ? 0 : 1);
      end
    end
    set_idle();

    // Mask is honoured only by the ternary instance.
    do_write(4'd1, 16'h00F0, 16'hFFFF, 1'b1);
    do_lookup("t6a", 16'h0000, 1'b1, 4'd1, 1'b0);
    check("t6a_bin_match", match[1], 0);
    do_lookup("t6b", 16'h00F0, 1'b1, 4'd1, 1'b0);
    check("t6b_bin_match", match[1], 1);

    // Asynchronous reset in the middle of a clear with lookups in flight.
    set_idle();
    clr = 1'b1;
    step();
    set_idle();
    step();
    step();
    cmp_req = 1'b1; cmp_din = 16'h00F0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    for (int t = 0; t < 2; t++) begin
      check($sformatf("rst_busy%0d", t), busy[t], 0);
      check($sformatf("rst_vld%0d", t), match_vld[t], 0);
    end
    model_reset();
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    do_lookup("t6c", 16'h00F0, 1'b0, 4'd0, 1'b0);

    // Random traffic over a small key space so hits, multi-hits and clears all occur.
    for (int c = 0; c < 2000; c++) begin
      set_idle();
      we       = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      din      = 16'h5A00 | 16'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0:       data_mask = 16'h0000;
        1:       data_mask = 16'h000F;
        2:       data_mask = 16'h0003;
        3:       data_mask = 16'hFFFF;
        default: data_mask = 16'($urandom);
      endcase
      wr_valid = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 99) == 0);
      cmp_req  = 1'($urandom_range(0, 1));
      cmp_din  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                             : (16'h5A00 | 16'($urandom_range(0, 15)));
      step();
    end
    set_idle();
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
